// File: rtl/darkriscv_pkg.sv
// Shared definitions for the darkmem load/store unit: opcodes, access-size
// codes, FSM state type and the byte-enable mask helper.
package darkriscv_pkg;

  localparam logic [6:0] LCC_OP = 7'b0000011;
  localparam logic [6:0] SCC_OP = 7'b0100011;

  typedef enum logic [2:0] {
    FB  = 3'd0,
    FH  = 3'd1,
    FW  = 3'd2,
    FD  = 3'd3,
    FBU = 3'd4,
    FHU = 3'd5,
    FWU = 3'd6
  } fct3_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Contiguous byte mask for the access size, moved to the addressed lane.
  function automatic logic [7:0] be_mask(input logic [1:0] size, input logic [2:0] offset);
    logic [7:0] m;
    unique case (size)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << offset;
  endfunction

endpackage

// File: rtl/darkmem_align.sv
// Byte-lane alignment, purely combinational.
// Store side: shifts right-justified data into its bus lane and builds byte enables.
// Load side: extracts the addressed bytes from a bus word and sign/zero-extends them.
module darkmem_align
  import darkriscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]                   st_size,
  input  logic [$clog2(XLEN/8)-1:0]    st_offset,
  input  logic [XLEN-1:0]              st_data,
  output logic [XLEN/8-1:0]            st_be,
  output logic [XLEN-1:0]              st_wdata,
  input  logic [1:0]                   ld_size,
  input  logic                         ld_zext,
  input  logic [$clog2(XLEN/8)-1:0]    ld_offset,
  input  logic [XLEN-1:0]              ld_data,
  output logic [XLEN-1:0]              ld_ext
);

  localparam int BW = XLEN / 8;

  logic [XLEN-1:0] ld_shift;
  logic            fill;
  int              nbits;

  // Store lane shift and byte-enable generation.
  always_comb begin
    st_be    = BW'(be_mask(st_size, 3'(st_offset)));
    st_wdata = st_data << {st_offset, 3'b000};
  end

  // Load extract: shift the addressed bytes down, then replicate the fill bit above them.
  always_comb begin
    ld_shift = ld_data >> {ld_offset, 3'b000};
    nbits    = XLEN;
    fill     = 1'b0;
    unique case (ld_size)
      2'd0: begin
        nbits = 8;
        fill  = ld_shift[7];
      end
      2'd1: begin
        nbits = 16;
        fill  = ld_shift[15];
      end
      2'd2: begin
        nbits = 32;
        fill  = ld_shift[31];
      end
      default: begin
        nbits = XLEN;
        fill  = ld_shift[XLEN-1];
      end
    endcase
    fill   = fill & ~ld_zext;
    ld_ext = '0;
    for (int i = 0; i < XLEN; i++) begin
      ld_ext[i] = (i < nbits) ? ld_shift[i] : fill;
    end
  end

endmodule

// File: rtl/darkmem_lsu.sv
// Load/store unit between the execute stage and the shared data bus.
// Optional bus timeout is enabled by defining DARKMEM_TIMEOUT_EN.
module darkmem_lsu
  import darkriscv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                res,
  input  logic                en,
  input  logic [31:0]         inst,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [XLEN-1:0]     data_i,
  output logic [XLEN-1:0]     data_o,
  output logic                busy,
  output logic                done,
  output logic                err_access,
  output logic                err_timeout,
  output logic                bus_en,
  output logic                bus_rw,
  output logic [XLEN/8-1:0]   bus_be,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [XLEN-1:0]     bus_wdata,
  input  logic [XLEN-1:0]     bus_rdata,
  input  logic                bus_valid
);

  localparam int BW = XLEN / 8;
  localparam int OW = $clog2(BW);

  logic [6:0]        opcode;
  logic [2:0]        fct3;
  logic              is_load;
  logic              is_store;
  logic              req;
  logic              bad_fct3;
  logic              misaligned;
  logic              unused_inst;

  state_t            state_q;
  logic [1:0]        size_q;
  logic              zext_q;
  logic [OW-1:0]     off_q;

  logic [BW-1:0]     st_be;
  logic [XLEN-1:0]   st_wdata;
  logic [XLEN-1:0]   ld_ext;

`ifdef DARKMEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]     cnt_q;
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  assign opcode      = inst[6:0];
  assign fct3        = inst[14:12];
  assign unused_inst = ^{inst[31:15], inst[11:7]};
  assign is_load     = (opcode == LCC_OP);
  assign is_store    = (opcode == SCC_OP);
  assign req         = en && (is_load || is_store);

  // Reject size codes the data path cannot carry and unsigned stores.
  always_comb begin
    bad_fct3 = 1'b0;
    if (XLEN == 32) begin
      bad_fct3 = (fct3 == FD) || (fct3 == FWU) || (fct3 == 3'd7);
    end else begin
      bad_fct3 = (fct3 == 3'd7);
    end
    if (is_store && fct3[2]) begin
      bad_fct3 = 1'b1;
    end
  end

  // Natural alignment check for the requested size.
  always_comb begin
    misaligned = 1'b0;
    unique case (fct3[1:0])
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = addr[0];
      2'd2:    misaligned = |addr[1:0];
      default: misaligned = |addr[2:0];
    endcase
  end

  darkmem_align #(
    .XLEN (XLEN)
  ) u_align (
    .st_size   (fct3[1:0]),
    .st_offset (addr[OW-1:0]),
    .st_data   (data_i),
    .st_be     (st_be),
    .st_wdata  (st_wdata),
    .ld_size   (size_q),
    .ld_zext   (zext_q),
    .ld_offset (off_q),
    .ld_data   (bus_rdata),
    .ld_ext    (ld_ext)
  );

  assign bus_en = (state_q == BUSY);
  // Stall the request cycle too; gated by reset so every output reads 0 in reset.
  assign busy   = res && ((state_q == BUSY) || req);

  // Transaction FSM with registered bus controls and status pulses.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q     <= IDLE;
      size_q      <= 2'd0;
      zext_q      <= 1'b0;
      off_q       <= '0;
      data_o      <= '0;
      done        <= 1'b0;
      err_access  <= 1'b0;
      err_timeout <= 1'b0;
      bus_rw      <= 1'b0;
      bus_be      <= '0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
`ifdef DARKMEM_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      done        <= 1'b0;
      err_access  <= 1'b0;
      err_timeout <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req) begin
            if (bad_fct3 || misaligned) begin
              err_access <= 1'b1;
            end else begin
              state_q   <= BUSY;
              size_q    <= fct3[1:0];
              zext_q    <= fct3[2];
              off_q     <= addr[OW-1:0];
              bus_rw    <= is_store;
              bus_be    <= st_be;
              bus_addr  <= addr & ~ADDR_W'(BW - 1);
              bus_wdata <= is_store ? st_wdata : '0;
`ifdef DARKMEM_TIMEOUT_EN
              cnt_q     <= '0;
`endif
            end
          end
        end
        default: begin
          if (bus_valid) begin
            state_q   <= IDLE;
            done      <= 1'b1;
            if (!bus_rw) begin
              data_o <= ld_ext;
            end
            bus_rw    <= 1'b0;
            bus_be    <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
          end
`ifdef DARKMEM_TIMEOUT_EN
          // This cycle is the TIMEOUT-th one without completion: abandon the access.
          else if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_q     <= IDLE;
            err_timeout <= 1'b1;
            bus_rw      <= 1'b0;
            bus_be      <= '0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_darkmem_lsu.sv
// Directed bench for darkmem_lsu: a 32-bit and a 64-bit instance share clock,
// reset, instruction, address and bus_valid; each has its own enable.
module tb_darkmem_lsu;

  logic        clk = 1'b0;
  logic        res;
  logic [31:0] inst;
  logic [31:0] addr;
  logic        bus_valid;

  logic        en32;
  logic [31:0] di32, do32, bwd32, brd32, baddr32;
  logic        busy32, done32, erra32, errt32, ben32, brw32;
  logic [3:0]  bbe32;

  logic        en64;
  logic [63:0] di64, do64, bwd64, brd64;
  logic [31:0] baddr64;
  logic        busy64, done64, erra64, errt64, ben64, brw64;
  logic [7:0]  bbe64;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  darkmem_lsu #(
    .XLEN    (32),
    .ADDR_W  (32),
    .TIMEOUT (4)
  ) u_dut32 (
    .clk         (clk),
    .res         (res),
    .en          (en32),
    .inst        (inst),
    .addr        (addr),
    .data_i      (di32),
    .data_o      (do32),
    .busy        (busy32),
    .done        (done32),
    .err_access  (erra32),
    .err_timeout (errt32),
    .bus_en      (ben32),
    .bus_rw      (brw32),
    .bus_be      (bbe32),
    .bus_addr    (baddr32),
    .bus_wdata   (bwd32),
    .bus_rdata   (brd32),
    .bus_valid   (bus_valid)
  );

  darkmem_lsu #(
    .XLEN    (64),
    .ADDR_W  (32),
    .TIMEOUT (4)
  ) u_dut64 (
    .clk         (clk),
    .res         (res),
    .en          (en64),
    .inst        (inst),
    .addr        (addr),
    .data_i      (di64),
    .data_o      (do64),
    .busy        (busy64),
    .done        (done64),
    .err_access  (erra64),
    .err_timeout (errt64),
    .bus_en      (ben64),
    .bus_rw      (brw64),
    .bus_be      (bbe64),
    .bus_addr    (baddr64),
    .bus_wdata   (bwd64),
    .bus_rdata   (brd64),
    .bus_valid   (bus_valid)
  );

  function automatic logic [31:0] ld_inst(input logic [2:0] f3);
    return {17'd0, f3, 5'd0, 7'b0000011};
  endfunction

  function automatic logic [31:0] st_inst(input logic [2:0] f3);
    return {17'd0, f3, 5'd0, 7'b0100011};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // 32-bit load with bus_valid in the first BUSY cycle; returns in the done cycle.
  task automatic load32(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] rd, input logic [3:0] be, input logic [31:0] exp);
    step();
    en32 = 1'b1; inst = ld_inst(f3); addr = a;
    #1;
    check({tag, "_busy_req"}, busy32, 1);
    step();
    en32 = 1'b0;
    #1;
    check({tag, "_bus_en"}, ben32, 1);
    check({tag, "_be"}, bbe32, be);
    check({tag, "_rw"}, brw32, 0);
    bus_valid = 1'b1; brd32 = rd;
    step();
    bus_valid = 1'b0;
    #1;
    check({tag, "_done"}, done32, 1);
    check({tag, "_data"}, do32, exp);
  endtask

  task automatic load64(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [63:0] rd, input logic [7:0] be, input logic [63:0] exp);
    step();
    en64 = 1'b1; inst = ld_inst(f3); addr = a;
    step();
    en64 = 1'b0;
    #1;
    check({tag, "_bus_en"}, ben64, 1);
    check({tag, "_be"}, bbe64, be);
    check({tag, "_addr"}, baddr64, a & 32'hFFFF_FFF8);
    bus_valid = 1'b1; brd64 = rd;
    step();
    bus_valid = 1'b0;
    #1;
    check({tag, "_done"}, done64, 1);
    check({tag, "_data"}, do64, exp);
  endtask

  task automatic access_err(input string tag, input logic [31:0] ins, input logic [31:0] a);
    step();
    en32 = 1'b1; inst = ins; addr = a;
    #1;
    check({tag, "_busy_req"}, busy32, 1);
    step();
    en32 = 1'b0;
    #1;
    check({tag, "_err"}, erra32, 1);
    check({tag, "_no_bus"}, ben32, 0);
    check({tag, "_busy_after"}, busy32, 0);
    step();
    check({tag, "_err_clr"}, erra32, 0);
    check({tag, "_no_bus2"}, ben32, 0);
  endtask

  initial begin
    res = 1'b0; en32 = 1'b0; en64 = 1'b0; bus_valid = 1'b0;
    inst = 32'd0; addr = 32'd0;
    di32 = '0; brd32 = '0; di64 = '0; brd64 = '0;
    step();
    check("rst_busy", busy32, 0);
    check("rst_bus_en", ben32, 0);
    check("rst_data", do32, 0);
    check("rst_done", done32, 0);
    check("rst_bus_en64", ben64, 0);
    res = 1'b1;

    // sb to lane 3, bus_valid on the third BUSY cycle
    step();
    en32 = 1'b1; inst = st_inst(3'd0); addr = 32'h1003; di32 = 32'h0000_00A5;
    #1;
    check("sb_busy_n", busy32, 1);
    check("sb_bus_en_n", ben32, 0);
    step();
    en32 = 1'b0;
    #1;
    check("sb_bus_en", ben32, 1);
    check("sb_be", bbe32, 4'b1000);
    check("sb_addr", baddr32, 32'h1000);
    check("sb_wdata", bwd32, 32'hA500_0000);
    check("sb_rw", brw32, 1);
    check("sb_busy_n1", busy32, 1);
    step();
    check("sb_busy_n2", busy32, 1);
    step();
    bus_valid = 1'b1;
    #1;
    check("sb_busy_n3", busy32, 1);
    check("sb_done_early", done32, 0);
    step();
    bus_valid = 1'b0;
    #1;
    check("sb_done", done32, 1);
    check("sb_busy_done", busy32, 0);
    check("sb_bus_en_off", ben32, 0);
    step();
    check("sb_done_pulse", done32, 0);

    // Load extraction and extension
    load32("lh", 3'd1, 32'h2002, 32'h8001_1234, 4'b1100, 32'hFFFF_8001);
    load32("lhu", 3'd5, 32'h2002, 32'h8001_1234, 4'b1100, 32'h0000_8001);
    load32("lb", 3'd0, 32'h2000, 32'h8001_1234, 4'b0001, 32'h0000_0034);

    // Back-to-back: sw accepted in the done cycle of lw
    load32("lw", 3'd2, 32'h2000, 32'h1234_5678, 4'b1111, 32'h1234_5678);
    check("b2b_busy_done_cycle_before_req", busy32, 0);
    en32 = 1'b1; inst = st_inst(3'd2); addr = 32'h2004; di32 = 32'hCAFE_F00D;
    #1;
    check("b2b_busy_req", busy32, 1);
    step();
    en32 = 1'b0;
    #1;
    check("b2b_bus_en", ben32, 1);
    check("b2b_rw", brw32, 1);
    check("b2b_wdata", bwd32, 32'hCAFE_F00D);
    check("b2b_addr", baddr32, 32'h2004);
    bus_valid = 1'b1;
    step();
    bus_valid = 1'b0;
    #1;
    check("b2b_done2", done32, 1);
    check("b2b_data_kept", do32, 32'h1234_5678);

    // Access errors
    access_err("lw_misal", ld_inst(3'd2), 32'h3002);
    access_err("ld_x32", ld_inst(3'd3), 32'h3000);
    access_err("sbu_illegal", st_inst(3'd4), 32'h3000);

    // 64-bit instance
    load64("ld64", 3'd3, 32'h8, 64'h8000_0000_0000_0001, 8'hFF, 64'h8000_0000_0000_0001);
    load64("lwu64", 3'd6, 32'hC, 64'h8000_0000_0000_0001, 8'hF0, 64'h0000_0000_8000_0000);
    load64("lw64", 3'd2, 32'hC, 64'h8000_0000_0000_0001, 8'hF0, 64'hFFFF_FFFF_8000_0000);

`ifdef DARKMEM_TIMEOUT_EN
    // Never acknowledged: abort after 4 BUSY cycles
    step();
    en32 = 1'b1; inst = ld_inst(3'd2); addr = 32'h4000;
    step();
    en32 = 1'b0;
    repeat (3) step();
    check("to_wait_bus_en", ben32, 1);
    check("to_wait_err", errt32, 0);
    step();
    check("to_err", errt32, 1);
    check("to_no_done", done32, 0);
    check("to_idle", ben32, 0);
    check("to_busy", busy32, 0);
    check("to_data_kept", do32, 32'hCAFE_F00D ^ 32'hCAFE_F00D ^ 32'h1234_5678);
    step();
    check("to_err_pulse", errt32, 0);
    // Completion on the 4th BUSY cycle wins over the limit
    en32 = 1'b1; inst = ld_inst(3'd2); addr = 32'h4000;
    step();
    en32 = 1'b0;
    repeat (3) step();
    bus_valid = 1'b1; brd32 = 32'h0BAD_CAFE;
    step();
    bus_valid = 1'b0;
    #1;
    check("to_late_done", done32, 1);
    check("to_late_noerr", errt32, 0);
    check("to_late_data", do32, 32'h0BAD_CAFE);
`else
    // No timeout: BUSY holds as long as the bus stays silent
    step();
    en32 = 1'b1; inst = ld_inst(3'd2); addr = 32'h4000;
    step();
    en32 = 1'b0;
    repeat (6) step();
    check("nto_bus_en", ben32, 1);
    check("nto_err", errt32, 0);
    check("nto_busy", busy32, 1);
    bus_valid = 1'b1; brd32 = 32'h0BAD_CAFE;
    step();
    bus_valid = 1'b0;
    #1;
    check("nto_done", done32, 1);
    check("nto_data", do32, 32'h0BAD_CAFE);
`endif

    // Reset in the middle of a transaction
    step();
    en32 = 1'b1; inst = ld_inst(3'd2); addr = 32'h5000;
    step();
    en32 = 1'b0;
    #1;
    check("rstmid_bus_en", ben32, 1);
    #2;
    res = 1'b0;
    #1;
    check("rstmid_bus_en_off", ben32, 0);
    check("rstmid_busy_off", busy32, 0);
    check("rstmid_data", do32, 0);
    step();
    check("rstmid_no_done", done32, 0);
    res = 1'b1;
    step();
    check("rstmid_still_idle", ben32, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/darkmem_lsu.md
Name: darkmem_lsu

Overview:
- Parametrised load/store unit between the core execute stage and the shared data bus.
- Decodes LCC/SCC from `inst` and byte-lane-aligns store data into bus words.
- Sign/zero-extends load data and raises a stall for the whole transaction.
- Adds alignment checking, XLEN=32/64 support and an optional bus timeout.

Parameters:
XLEN, 32, data path width; legal values 32 or 64; bus data width = XLEN, byte-enable width = XLEN/8
ADDR_W, 32, address width
TIMEOUT, 255, maximum BUSY cycles without bus_valid before abort (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
res  in  1  reset, asynchronous, active-low (0 = reset)
en  in  1  stage enable; a request is sampled only when en=1
inst  in  32  instruction; [6:0] opcode (LCC=0000011, SCC=0100011), [14:12] fct3
addr  in  ADDR_W  effective byte address
data_i  in  XLEN  store data (rs2), right-justified
data_o  out  XLEN  load result, extended, registered
busy  out  1  stall to core
done  out  1  one-cycle pulse at transaction completion
err_access  out  1  one-cycle pulse: misaligned access or fct3 illegal for XLEN
err_timeout  out  1  one-cycle pulse: bus timeout
bus_en  out  1  bus request
bus_rw  out  1  1 = write
bus_be  out  XLEN/8  byte enables
bus_addr  out  ADDR_W  address, low log2(XLEN/8) bits forced to 0
bus_wdata  out  XLEN  lane-shifted store data
bus_rdata  in  XLEN  read data
bus_valid  in  1  bus completion, one cycle

Behaviour:
- Reset (res=0, async): state=IDLE; all outputs 0; data_o=0; timeout counter=0.
- FSM has two states: IDLE and BUSY.
- Request = en && (opcode==LCC || opcode==SCC).
- Size from fct3[1:0]: 0=byte, 1=half, 2=word, 3=double.
- fct3[2]=1 means zero-extend (lbu/lhu/lwu).
- fct3 illegal when:
  - XLEN=32: fct3 in {3,6,7}.
  - XLEN=64: fct3==7.
  - Any store with fct3[2]=1.
- Misaligned when any of: half with addr[0]!=0; word with addr[1:0]!=0; double with addr[2:0]!=0.
- IDLE, legal request:
  - Latch addr, fct3, rw and lane offset.
  - bus_be = size mask shifted left by offset.
  - bus_wdata = data_i << 8*offset.
  - Go to BUSY next edge.
  - busy=1 combinationally in the same cycle.
- IDLE, illegal or misaligned request: err_access=1 registered next cycle; no bus activity; stay IDLE; busy=1 for the request cycle only.
- BUSY:
  - bus_en=1; bus_rw, bus_be, bus_addr, bus_wdata held stable; busy=1.
  - On bus_valid: return to IDLE; done=1 next cycle.
  - On a load, data_o = extend(bus_rdata >> 8*offset) registered on the same edge.
  - Stores leave data_o unchanged.
- busy drops in the cycle done is high, so the core advances exactly once per transaction.
- Minimum latency: request cycle N → bus_en cycle N+1 → with bus_valid at N+1, done/data_o at N+2.
- en=0 while BUSY: the transaction continues; en gates only new requests.
- bus_valid in IDLE: ignored.
- Reset mid-transaction: immediate IDLE; bus_en drops asynchronously; no done.
- Back-to-back requests: the next request is accepted in the cycle done is asserted (state is IDLE).

Optional Feature:
- Macro: DARKMEM_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT+1) increments every BUSY cycle without bus_valid.
  - When the count reaches TIMEOUT: return to IDLE, pulse err_timeout next cycle, no done, data_o unchanged.
  - bus_valid in the same cycle as the limit wins (normal completion).
  - The counter clears on entry to BUSY.
- Undefined: no counter; BUSY waits indefinitely; err_timeout tied 0.

Decomposition:
- Package darkriscv_pkg:
  - opcode constants LCC_OP and SCC_OP.
  - fct3 enum {FB=0, FH=1, FW=2, FD=3, FBU=4, FHU=5, FWU=6}.
  - state_t {IDLE, BUSY}.
  - function be_mask(size, offset).
- Sub-module darkmem_align: purely combinational.
  - Store-side lane shift / byte-enable generation.
  - Load-side extract and sign/zero extension.
  - Instantiated once; reusable by a future I-cache fill path.

Test Plan:
1. XLEN=32, sb addr=0x1003, data_i=0x000000A5 → bus_be=1000, bus_addr=0x1000, bus_wdata=0xA5000000, bus_rw=1; bus_valid after 3 cycles → done pulse, busy 1 for 4 cycles total.
2. lh addr=0x2002, bus_rdata=0x8001_1234 → data_o=0xFFFF8001; lhu same → 0x00008001; lb addr=0x2000 → 0x00000034.
3. lw addr=0x3002 → err_access pulse, bus_en never asserted; fct3=3 at XLEN=32 → err_access.
4. XLEN=64, ld addr=0x8, bus_rdata=0x8000_0000_0000_0001 → bus_be=0xFF, data_o=0x8000000000000001; lwu addr=0xC → 0x0000000080000000.
5. DARKMEM_TIMEOUT_EN, TIMEOUT=4, lw never acknowledged → err_timeout pulse 5 cycles after request, state IDLE, no done; bus_valid on the 4th BUSY cycle → done, no err_timeout.
6. res=0 asserted mid-BUSY → bus_en and busy 0 immediately, no done; sw issued in the done cycle of a prior lw → accepted, two done pulses.
